// File: rtl/reorder_buffer.sv
// In-order retirement buffer: tagged allocation, CDB capture, single commit,
// and a global flush when a mispredicted branch reaches the head.
module reorder_buffer #(
  parameter int ROB_W = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             from_decoder_valid,
  input  logic             from_decoder_has_dest,
  input  logic [4:0]       from_decoder_rd,
  input  logic             from_decoder_is_branch,
  input  logic             from_decoder_pred_taken,
  output logic             to_decoder_full,
  output logic [ROB_W-1:0] to_decoder_tag,
  input  logic [ROB_W-1:0] from_decoder_qtag1,
  input  logic [ROB_W-1:0] from_decoder_qtag2,
  output logic             to_decoder_qready1,
  output logic             to_decoder_qready2,
  output logic [31:0]      to_decoder_qdata1,
  output logic [31:0]      to_decoder_qdata2,
  input  logic             from_cdb_valid,
  input  logic [ROB_W-1:0] from_cdb_tag,
  input  logic [31:0]      from_cdb_data,
  input  logic             from_cdb_taken,
  input  logic [31:0]      from_cdb_target,
  output logic             to_rf_write_enabled,
  output logic [4:0]       to_rf_reg_id,
  output logic [31:0]      to_rf_data,
  output logic [ROB_W-1:0] to_rf_rob_id,
  output logic             flush_out,
  output logic [31:0]      flush_pc
);

  localparam int NE = 2 ** ROB_W;
  localparam logic [ROB_W-1:0] LAST = '1;
  localparam logic [ROB_W-1:0] ONE  = ROB_W'(1);

  logic [NE-1:0]    busy_q, rdy_q, hd_q, br_q, pred_q, mis_q;
  logic [4:0]       rd_q   [NE];
  logic [31:0]      data_q [NE];
  logic [31:0]      tgt_q  [NE];
  logic [ROB_W-1:0] head_q, tail_q, count_q, count_d;
  logic             we_q, flush_q;
  logic [4:0]       rf_rd_q;
  logic [31:0]      rf_data_q, flush_pc_q;
  logic [ROB_W-1:0] rf_rob_q, rob_d, idx;
  logic             full, alloc, cdb_hit, commit, mis_commit;

  function automatic logic [ROB_W-1:0] nxt(input logic [ROB_W-1:0] p);
    return (p == LAST) ? ONE : p + ONE;
  endfunction

  function automatic logic [32:0] lookup(input logic [ROB_W-1:0] t);
    logic [32:0] r;
    r = '0;
    if (t == '0)
      r = {1'b1, 32'd0};
    else if (busy_q[t] && rdy_q[t])
      r = {1'b1, data_q[t]};
    else if (from_cdb_valid && !flush_q && from_cdb_tag == t)
      r = {1'b1, from_cdb_data};
    return r;
  endfunction

  assign full       = (count_q == LAST);
  assign alloc      = from_decoder_valid && !full && !flush_q;
  assign cdb_hit    = from_cdb_valid && !flush_q &&
                      from_cdb_tag != '0 && busy_q[from_cdb_tag];
  assign commit     = !flush_q && count_q != '0 && rdy_q[head_q];
  assign mis_commit = commit && mis_q[head_q];

  assign to_decoder_full = full;
  assign to_decoder_tag  = tail_q;
  assign {to_decoder_qready1, to_decoder_qdata1} = lookup(from_decoder_qtag1);
  assign {to_decoder_qready2, to_decoder_qdata2} = lookup(from_decoder_qtag2);

  always_comb begin
    count_d = count_q;
    if (alloc && !commit)
      count_d = count_q + ONE;
    else if (!alloc && commit)
      count_d = count_q - ONE;
  end

  // Youngest other producer of the head's rd: ring order, then this cycle's alloc.
  always_comb begin
    rob_d = '0;
    idx   = head_q;
    for (int k = 1; k < NE - 1; k++) begin
      idx = nxt(idx);
      if (k < int'(count_q) && hd_q[idx] && rd_q[idx] == rd_q[head_q])
        rob_d = idx;
    end
    if (alloc && from_decoder_has_dest && from_decoder_rd == rd_q[head_q])
      rob_d = tail_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q     <= '0;
      rdy_q      <= '0;
      head_q     <= ONE;
      tail_q     <= ONE;
      count_q    <= '0;
      we_q       <= 1'b0;
      rf_rd_q    <= '0;
      rf_data_q  <= '0;
      rf_rob_q   <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      we_q    <= 1'b0;
      flush_q <= 1'b0;
      if (mis_commit) begin
        busy_q     <= '0;
        rdy_q      <= '0;
        head_q     <= ONE;
        tail_q     <= ONE;
        count_q    <= '0;
        flush_q    <= 1'b1;
        flush_pc_q <= tgt_q[head_q];
      end else begin
        if (cdb_hit) begin
          rdy_q[from_cdb_tag]  <= 1'b1;
          data_q[from_cdb_tag] <= from_cdb_data;
          tgt_q[from_cdb_tag]  <= from_cdb_target;
          mis_q[from_cdb_tag]  <= br_q[from_cdb_tag] &&
                                  (from_cdb_taken != pred_q[from_cdb_tag]);
        end
        if (commit) begin
          busy_q[head_q] <= 1'b0;
          rdy_q[head_q]  <= 1'b0;
          head_q         <= nxt(head_q);
          we_q           <= hd_q[head_q] && rd_q[head_q] != 5'd0;
          rf_rd_q        <= rd_q[head_q];
          rf_data_q      <= data_q[head_q];
          rf_rob_q       <= rob_d;
        end
        if (alloc) begin
          busy_q[tail_q] <= 1'b1;
          rdy_q[tail_q]  <= 1'b0;
          hd_q[tail_q]   <= from_decoder_has_dest;
          rd_q[tail_q]   <= from_decoder_rd;
          br_q[tail_q]   <= from_decoder_is_branch;
          pred_q[tail_q] <= from_decoder_pred_taken;
          mis_q[tail_q]  <= 1'b0;
          tail_q         <= nxt(tail_q);
        end
        count_q <= count_d;
      end
    end
  end

  assign to_rf_write_enabled = we_q;
  assign to_rf_reg_id        = rf_rd_q;
  assign to_rf_data          = rf_data_q;
  assign to_rf_rob_id        = rf_rob_q;
  assign flush_out           = flush_q;
  assign flush_pc            = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Random + directed bench for reorder_buffer against a queue-based model.
module tb_reorder_buffer;

  localparam int N = 7;

  logic clk = 1'b0;
  logic rst;
  logic dv, dhd, dbr, dpr;
  logic [4:0] drd;
  logic full;
  logic [2:0] dtag, qt1, qt2, ctag;
  logic qr1, qr2;
  logic [31:0] qd1, qd2;
  logic cv, ctk;
  logic [31:0] cdata, ctgt;
  logic we, fl;
  logic [4:0] rrd;
  logic [31:0] rdata, fpc;
  logic [2:0] rrob;

  always #5 clk = ~clk;

  reorder_buffer #(.ROB_W(3)) dut (
    .clk_in(clk), .rst_in(rst),
    .from_decoder_valid(dv), .from_decoder_has_dest(dhd),
    .from_decoder_rd(drd), .from_decoder_is_branch(dbr),
    .from_decoder_pred_taken(dpr),
    .to_decoder_full(full), .to_decoder_tag(dtag),
    .from_decoder_qtag1(qt1), .from_decoder_qtag2(qt2),
    .to_decoder_qready1(qr1), .to_decoder_qready2(qr2),
    .to_decoder_qdata1(qd1), .to_decoder_qdata2(qd2),
    .from_cdb_valid(cv), .from_cdb_tag(ctag), .from_cdb_data(cdata),
    .from_cdb_taken(ctk), .from_cdb_target(ctgt),
    .to_rf_write_enabled(we), .to_rf_reg_id(rrd), .to_rf_data(rdata),
    .to_rf_rob_id(rrob), .flush_out(fl), .flush_pc(fpc)
  );

  typedef struct {
    int tag; bit hd; int rd; bit br; bit pred;
    bit rdy; int unsigned data; bit mis; int unsigned tgt;
  } ent_t;

  ent_t q[$];
  int tail_m = 1;
  bit fl_m = 0;
  bit e_we, e_fl;
  int e_rd, e_rob;
  int unsigned e_data, e_pc;
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void qmodel(input int t, output bit r,
                                 output int unsigned d);
    r = 0; d = 0;
    if (t == 0) begin r = 1; return; end
    foreach (q[i])
      if (q[i].tag == t && q[i].rdy) begin
        r = 1; d = q[i].data; return;
      end
    if (cv && !fl_m && int'(ctag) == t) begin r = 1; d = cdata; end
  endfunction

  task automatic model_edge();
    bit alloc, commit;
    ent_t e;
    e_we = 0; e_fl = 0;
    if (rst) begin
      q.delete(); tail_m = 1; fl_m = 0;
      e_rd = 0; e_rob = 0; e_data = 0; e_pc = 0;
      return;
    end
    if (fl_m) begin fl_m = 0; return; end
    alloc  = dv && q.size() < N;
    commit = q.size() > 0 && q[0].rdy;
    if (commit && q[0].mis) begin
      e_fl = 1; e_pc = q[0].tgt;
      q.delete(); tail_m = 1; fl_m = 1;
      return;
    end
    if (commit) begin
      e_we = q[0].hd && q[0].rd != 0;
      e_rd = q[0].rd; e_data = q[0].data; e_rob = 0;
      for (int i = 1; i < q.size(); i++)
        if (q[i].hd && q[i].rd == q[0].rd) e_rob = q[i].tag;
      if (alloc && dhd && int'(drd) == q[0].rd) e_rob = tail_m;
    end
    if (cv && ctag != 0)
      foreach (q[i])
        if (q[i].tag == int'(ctag)) begin
          q[i].rdy = 1; q[i].data = cdata; q[i].tgt = ctgt;
          q[i].mis = q[i].br && (ctk != q[i].pred);
        end
    if (commit) void'(q.pop_front());
    if (alloc) begin
      e = '{tail_m, dhd, int'(drd), dbr, dpr, 1'b0, 0, 1'b0, 0};
      q.push_back(e);
      tail_m = (tail_m == N) ? 1 : tail_m + 1;
    end
  endtask

  task automatic step();
    bit r; int unsigned d;
    @(negedge clk);
    if (!rst) begin
      check("full", full, q.size() == N);
      check("tag", dtag, tail_m);
      qmodel(qt1, r, d);
      check("qready1", qr1, r);
      if (r) check("qdata1", qd1, d);
      qmodel(qt2, r, d);
      check("qready2", qr2, r);
      if (r) check("qdata2", qd2, d);
    end
    @(posedge clk);
    model_edge();
    #1;
    check("rf_we", we, e_we);
    check("flush", fl, e_fl);
    if (e_we || rst) begin
      check("rf_rd", rrd, e_rd);
      check("rf_data", rdata, e_data);
      check("rf_rob", rrob, e_rob);
    end
    if (e_fl || rst) check("flush_pc", fpc, e_pc);
  endtask

  task automatic idle();
    rst = 0; dv = 0; dhd = 0; drd = 0; dbr = 0; dpr = 0;
    qt1 = 0; qt2 = 0; cv = 0; ctag = 0; cdata = 0; ctk = 0; ctgt = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step();
    idle(); #1;
    check("rst_full", full, 0);
    check("rst_tag", dtag, 1);
  endtask

  task automatic alloc(input int rd);
    idle(); dv = 1; dhd = 1; drd = 5'(rd); step();
  endtask

  task automatic cdb(input int t, input int unsigned d);
    idle(); cv = 1; ctag = 3'(t); cdata = d; step();
  endtask

  task automatic rand_cycle();
    int cand[$];
    idle();
    rst = ($urandom_range(0, 499) == 0);
    dv  = ($urandom_range(0, 2) != 0);
    dhd = ($urandom_range(0, 4) != 0);
    drd = 5'($urandom_range(0, 7));
    dbr = ($urandom_range(0, 4) == 0);
    dpr = 1'($urandom);
    foreach (q[i]) if (!q[i].rdy) cand.push_back(q[i].tag);
    cv = ($urandom_range(0, 9) < 7);
    if (cand.size() > 0 && $urandom_range(0, 9) != 0)
      ctag = 3'(cand[$urandom_range(0, cand.size() - 1)]);
    else
      ctag = 3'($urandom_range(0, 7));
    cdata = $urandom; ctk = 1'($urandom); ctgt = $urandom;
    qt1 = 3'($urandom_range(0, 7));
    qt2 = ($urandom_range(0, 1) == 1) ? ctag : 3'($urandom_range(0, 7));
    step();
  endtask

  initial begin
    // 1: out-of-order completion, in-order commit
    do_reset();
    alloc(5); alloc(6); alloc(7);
    cdb(3, 32'h33); cdb(1, 32'h11); cdb(2, 32'h22);
    idle(); repeat (4) step();

    // 2: fill, drop, wrap
    do_reset();
    for (int i = 0; i < N; i++) alloc(i + 1);
    #1 check("t2_full", full, 1);
    check("t2_wrap_tag", dtag, 1);
    alloc(9);
    cdb(1, 32'hA1);
    idle(); step();
    alloc(10);
    check("t2_tail", dtag, 2);

    // 3: rename tag hand-off
    do_reset();
    alloc(5); alloc(5);
    cdb(1, 32'h1); cdb(2, 32'h2);
    check("t3_rob1", rrob, 2);
    idle(); step();
    check("t3_rob2", rrob, 0);

    // 4: mispredict flush
    do_reset();
    idle(); dv = 1; dbr = 1; dpr = 0; step();
    alloc(3);
    idle(); cv = 1; ctag = 1; ctk = 1; ctgt = 32'h100; step();
    idle(); step();
    check("t4_flush", fl, 1);
    check("t4_pc", fpc, 32'h100);
    idle(); step();
    check("t4_tag", dtag, 1);
    alloc(4);

    // 5: query bypass from the CDB
    do_reset();
    for (int i = 0; i < 4; i++) alloc(i + 1);
    idle(); cv = 1; ctag = 4; cdata = 32'hDEAD; qt1 = 4; #1;
    check("t5_qready", qr1, 1);
    check("t5_qdata", qd1, 32'hDEAD);
    step();

    // 6: rd = 0 commits without a write
    do_reset();
    alloc(0); alloc(8);
    cdb(1, 32'h5); cdb(2, 32'h6);
    check("t6_we", we, 0);
    idle(); step();

    do_reset();
    repeat (3000) rand_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
